// File: rtl/data_mem_ctrl.sv
// RV32 data memory: byte-lane stores, sign/zero-extending loads, req/ready/respValid handshake,
// optional wait states. Define DATAMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors.
module data_mem_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_WORDS     = 1024,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  output logic                     ready,
  input  logic                     we,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [31:0]              writeData,
  output logic [31:0]              readData,
  output logic                     respValid,
  output logic                     error,
  output logic [1:0]               fsm_state
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Handshake: a request is accepted on every rising edge where req && ready; the requester
  // holds req and its operands until then. Each accepted request yields exactly one respValid
  // pulse, with readData/error valid in that same cycle. There is no back-pressure on responses.

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     accept;
  logic                     exec;

  logic                     req_we_q;
  logic [2:0]               req_f3_q;
  logic [ADDRESS_WIDTH-1:0] req_addr_q;
  logic [31:0]              req_wdata_q;

  logic                     e_we;
  logic [2:0]               e_f3;
  logic [ADDRESS_WIDTH-1:0] e_addr;
  logic [31:0]              e_wdata;

  logic [31:0]              mem [MEM_WORDS];
  logic [IDX_W-1:0]         word_idx;
  logic [31:0]              rd_word;
  logic [1:0]               off_eff;
  logic [4:0]               sh_amt;
  logic [31:0]              rd_shift;
  logic [31:0]              wr_shift;
  logic [3:0]               lane_en;
  logic                     legal;
  logic [31:0]              load_val;
  logic                     mem_we;
  logic                     unused_addr_hi;

  assign accept    = req && ready;
  assign ready     = (state_q != BUSY);
  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // With no wait states the access happens straight off the ports and the FSM idles forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    if (WAIT_CYCLES == 0) begin
      exec = accept;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            exec    = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (accept) begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q    <= 1'b0;
      req_f3_q    <= 3'd0;
      req_addr_q  <= '0;
      req_wdata_q <= 32'd0;
    end else if (accept) begin
      req_we_q    <= we;
      req_f3_q    <= funct3;
      req_addr_q  <= address;
      req_wdata_q <= writeData;
    end
  end

  assign e_we    = (WAIT_CYCLES == 0) ? we        : req_we_q;
  assign e_f3    = (WAIT_CYCLES == 0) ? funct3    : req_f3_q;
  assign e_addr  = (WAIT_CYCLES == 0) ? address   : req_addr_q;
  assign e_wdata = (WAIT_CYCLES == 0) ? writeData : req_wdata_q;

  // Address bits above the word index wrap modulo MEM_WORDS.
  assign word_idx       = e_addr[IDX_W+1:2];
  assign unused_addr_hi = ^e_addr[ADDRESS_WIDTH-1:IDX_W+2];
  assign rd_word        = mem[word_idx];

  always_comb begin
    legal   = 1'b1;
    off_eff = e_addr[1:0];
    lane_en = 4'b0000;
    case (e_f3)
      3'b000, 3'b100: begin
        lane_en = 4'b0001 << off_eff;
        if (e_f3[2] && e_we) legal = 1'b0;
      end
      3'b001, 3'b101: begin
        off_eff = {e_addr[1], 1'b0};
        lane_en = 4'b0011 << off_eff;
        if (e_f3[2] && e_we) legal = 1'b0;
`ifdef DATAMEM_MISALIGN_TRAP_EN
        if (e_addr[0]) legal = 1'b0;
`endif
      end
      3'b010: begin
        off_eff = 2'b00;
        lane_en = 4'b1111;
`ifdef DATAMEM_MISALIGN_TRAP_EN
        if (e_addr[1:0] != 2'b00) legal = 1'b0;
`endif
      end
      default: legal = 1'b0;
    endcase
  end

  assign sh_amt   = {off_eff, 3'b000};
  assign rd_shift = rd_word >> sh_amt;
  assign wr_shift = e_wdata << sh_amt;
  assign mem_we   = exec && legal && e_we;

  always_comb begin
    load_val = 32'd0;
    case (e_f3)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_val = rd_shift;
      3'b100:  load_val = {24'd0, rd_shift[7:0]};
      3'b101:  load_val = {16'd0, rd_shift[15:0]};
      default: load_val = 32'd0;
    endcase
  end

  // The array is never reset; a store dropped by reset simply never reaches this write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= wr_shift[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      respValid <= 1'b0;
      readData  <= 32'd0;
      error     <= 1'b0;
    end else if (exec) begin
      respValid <= 1'b1;
      error     <= !legal;
      readData  <= (legal && !e_we) ? load_val : 32'd0;
    end else begin
      respValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance with no wait states, one with three, checked against
// a byte-array reference model with an expected queue for back-to-back traffic.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst0, rst3;
  logic        req0, req3, we0, we3, rdy0, rdy3, rv0, rv3, err0, err3;
  logic [2:0]  f0, f3;
  logic [31:0] a0, a3, wd0, wd3, rd0, rd3;
  logic [1:0]  st0, st3;

  logic [7:0]  mem_b [0:1][0:4095];
  logic [31:0] exp_q [$];
  logic        exp_e_q [$];
  int          tests_run, tests_failed;

  data_mem_ctrl #(.ADDRESS_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0), .req(req0), .ready(rdy0), .we(we0), .funct3(f0), .address(a0),
    .writeData(wd0), .readData(rd0), .respValid(rv0), .error(err0), .fsm_state(st0));

  data_mem_ctrl #(.ADDRESS_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3), .req(req3), .ready(rdy3), .we(we3), .funct3(f3), .address(a3),
    .writeData(wd3), .readData(rd3), .respValid(rv3), .error(err3), .fsm_state(st3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: 4 KiB byte array per instance, address taken modulo 4096.
  task automatic model(input int inst, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic err);
    int b, size;
    logic sgn;
    logic [31:0] val, mask;
    b = int'(a % 4096);
    err = 1'b0; rd = 32'd0; size = 4; sgn = 1'b0;
    case (f)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; sgn = 1'b0; end
      3'd4: begin size = 1; sgn = 1'b0; err = w; end
      3'd5: begin size = 2; sgn = 1'b0; err = w; end
      default: err = 1'b1;
    endcase
    if (!err && (b % size) != 0) begin
`ifdef DATAMEM_MISALIGN_TRAP_EN
      err = 1'b1;
`else
      b = b - (b % size);
`endif
    end
    if (err) return;
    if (w) begin
      for (int k = 0; k < size; k++) mem_b[inst][b+k] = d[8*k +: 8];
    end else begin
      val = 32'd0;
      for (int k = 0; k < size; k++) val = val | (32'(mem_b[inst][b+k]) << (8*k));
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
      if (sgn && val[8*size-1]) val = val | ~mask;
      rd = val;
    end
  endtask

  task automatic drive(input int inst, input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    if (inst == 0) begin req0 = r; we0 = w; f0 = f; a0 = a; wd0 = d; end
    else begin req3 = r; we3 = w; f3 = f; a3 = a; wd3 = d; end
  endtask

  function automatic logic get_rdy(input int inst);
    return (inst == 0) ? rdy0 : rdy3;
  endfunction
  function automatic logic get_rv(input int inst);
    return (inst == 0) ? rv0 : rv3;
  endfunction

  // One complete access: wait for ready, accept, check latency, data, error and pulse width.
  task automatic access(input int inst, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    logic exp_err, got;
    int cyc, lat;
    model(inst, w, f, a, d, exp_rd, exp_err);
    @(negedge clk);
    drive(inst, 1'b1, w, f, a, d);
    cyc = 0;
    while (!get_rdy(inst) && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) check_eq("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 drive(inst, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    got = 1'b0; lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = get_rv(inst);
    end
    got_rd  = (inst == 0) ? rd0 : rd3;
    got_err = (inst == 0) ? err0 : err3;
    if (!got) begin
      check_eq("resp_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("latency", 32'(lat), (inst == 0) ? 32'd1 : 32'd4);
      check_eq("read_data", got_rd, exp_rd);
      check_eq("error", 32'(got_err), 32'(exp_err));
      @(negedge clk);
      check_eq("pulse_width", 32'(get_rv(inst)), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r, a, d, prev_a;
    logic e, w;
    logic [2:0] f;
    int pulses;
    tests_run = 0; tests_failed = 0;
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    #12;
    check_eq("rst_ready0", 32'(rdy0), 32'd1);
    check_eq("rst_rv0", 32'(rv0), 32'd0);
    check_eq("rst_rd0", rd0, 32'd0);
    check_eq("rst_err0", 32'(err0), 32'd0);
    check_eq("rst_ready3", 32'(rdy3), 32'd1);
    check_eq("rst_rv3", 32'(rv3), 32'd0);
    @(negedge clk); rst0 = 1'b1; rst3 = 1'b1;

    // Prefill the first 64 words of both instances so every later read is defined.
    for (int i = 0; i < 64; i++) begin
      access(0, 1'b1, 3'd2, 32'(i*4), $urandom, r, e);
      access(3, 1'b1, 3'd2, 32'(i*4), $urandom, r, e);
    end

    // Sign/zero extension of a byte.
    access(0, 1'b1, 3'd2, 32'h10, 32'h8000_00F1, r, e);
    access(0, 1'b0, 3'd0, 32'h10, 32'd0, r, e);
    check_eq("lb_sext", r, 32'hFFFF_FFF1);
    access(0, 1'b0, 3'd4, 32'h10, 32'd0, r, e);
    check_eq("lbu_zext", r, 32'h0000_00F1);

    // Byte and half lane stores.
    access(0, 1'b1, 3'd2, 32'h10, 32'h1122_3344, r, e);
    access(0, 1'b1, 3'd0, 32'h13, 32'h0000_00AB, r, e);
    access(0, 1'b0, 3'd2, 32'h10, 32'd0, r, e);
    check_eq("sb_lane3", r, 32'hAB22_3344);
    access(0, 1'b1, 3'd1, 32'h12, 32'h0000_BEEF, r, e);
    access(0, 1'b0, 3'd2, 32'h10, 32'd0, r, e);
    check_eq("sh_upper", r, 32'hBEEF_3344);
    access(0, 1'b0, 3'd1, 32'h12, 32'd0, r, e);
    check_eq("lh_sext", r, 32'hFFFF_BEEF);

    // Misaligned word load: trap or align-down depending on build.
    access(0, 1'b0, 3'd2, 32'h11, 32'd0, r, e);
`ifdef DATAMEM_MISALIGN_TRAP_EN
    check_eq("misalign_err", 32'(e), 32'd1);
    check_eq("misalign_rd", r, 32'd0);
`else
    check_eq("misalign_err", 32'(e), 32'd0);
    check_eq("misalign_rd", r, 32'hBEEF_3344);
`endif
    // Illegal funct3 and SBU: error and no write.
    access(0, 1'b1, 3'd3, 32'h10, 32'hFFFF_FFFF, r, e);
    check_eq("f011_err", 32'(e), 32'd1);
    access(0, 1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF, r, e);
    check_eq("sbu_err", 32'(e), 32'd1);
    access(0, 1'b0, 3'd2, 32'h10, 32'd0, r, e);
    check_eq("no_write", r, 32'hBEEF_3344);

    // Wrap: upper address bits are ignored.
    access(0, 1'b0, 3'd2, 32'hABCD_1010, 32'd0, r, e);
    check_eq("wrap", r, 32'hBEEF_3344);

    // Wait states: ready low for three cycles, held req not accepted twice.
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
    model(3, 1'b0, 3'd2, 32'h10, 32'd0, d, e);
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_eq("busy_ready", 32'(rdy3), 32'd0);
      check_eq("busy_rv", 32'(rv3), 32'd0);
    end
    drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check_eq("resp_rv", 32'(rv3), 32'd1);
    check_eq("resp_ready", 32'(rdy3), 32'd1);
    check_eq("resp_rd", rd3, d);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (rv3) pulses++; end
    check_eq("no_double_accept", 32'(pulses), 32'd0);

    // Reset in BUSY drops the pending store.
    access(3, 1'b1, 3'd2, 32'h20, 32'h1234_5678, r, e);
    access(3, 1'b0, 3'd2, 32'h20, 32'd0, r, e);
    @(negedge clk);
    drive(3, 1'b1, 1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check_eq("midrst_rv", 32'(rv3), 32'd0);
    check_eq("midrst_ready", 32'(rdy3), 32'd1);
    check_eq("midrst_rd", rd3, 32'd0);
    check_eq("midrst_err", 32'(err3), 32'd0);
    @(negedge clk); @(negedge clk);
    rst3 = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (rv3) pulses++; end
    check_eq("midrst_no_resp", 32'(pulses), 32'd0);
    access(3, 1'b0, 3'd2, 32'h20, 32'd0, r, e);
    check_eq("midrst_old_data", r, 32'h1234_5678);

    // Random single accesses through the wait-state instance.
    for (int i = 0; i < 40; i++) begin
      a = $urandom; a[11:0] = 12'($urandom_range(0, 255));
      access(3, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, r, e);
    end

    // Back-to-back random traffic on the zero-wait instance, scoreboarded through exp_q.
    prev_a = 32'h10;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("b2b_rv", 32'(rv0), 32'd1);
        if (exp_q.size() > 0) begin
          check_eq("b2b_rd", rd0, exp_q.pop_front());
          check_eq("b2b_err", 32'(err0), 32'(exp_e_q.pop_front()));
        end
      end
      if (i < 60) begin
        if (i % 3 == 1) begin
          a = prev_a; w = 1'b0; f = 3'd2;
        end else begin
          a = $urandom; a[11:0] = 12'($urandom_range(0, 255));
          w = 1'($urandom_range(0, 1));
          f = 3'($urandom_range(0, 7));
        end
        d = $urandom;
        model(0, w, f, a, d, r, e);
        exp_q.push_back(r);
        exp_e_q.push_back(e);
        drive(0, 1'b1, w, f, a, d);
        prev_a = a;
      end else begin
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      end
    end
    @(negedge clk);
    check_eq("b2b_idle", 32'(rv0), 32'd0);
    check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
